// File: rtl/window_scan_ctrl.sv
// Window-position sequencer: accepts one scale configuration and emits the
// raster-ordered window positions for it, flagging the frame's final window.
module window_scan_ctrl #(
    parameter int unsigned IMG_WIDTH  = 45,
    parameter int unsigned IMG_HEIGHT = 45,
    parameter int unsigned WIN_W      = 24,
    parameter int unsigned WIN_H      = 24,
    parameter int unsigned STEP_X     = 1,
    parameter int unsigned STEP_Y     = 1,
    localparam int unsigned W_X = $clog2(IMG_WIDTH),
    localparam int unsigned W_Y = $clog2(IMG_HEIGHT),
    localparam int unsigned W_W = $clog2(IMG_WIDTH + 1),
    localparam int unsigned W_H = $clog2(IMG_HEIGHT + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [W_W-1:0] cfg_width,
    input  logic [W_H-1:0] cfg_height,
    input  logic [7:0]     cfg_scale,
    input  logic           cfg_last,
    output logic           cfg_err,
    output logic           window_pos_valid,
    input  logic           window_pos_ready,
    output logic           window_pos_eot,
    output logic [7:0]     window_pos_scale,
    output logic [W_X-1:0] window_pos_x,
    output logic [W_Y-1:0] window_pos_y,
    output logic           busy,
    output logic           frame_done
);

    localparam int unsigned W_CX = W_W + 1;
    localparam int unsigned W_CY = W_H + 1;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t         state, state_n;
    logic [W_X-1:0] x_q, x_n;
    logic [W_Y-1:0] y_q, y_n;
    logic [W_W-1:0] xmax_q, xmax_n;
    logic [W_H-1:0] ymax_q, ymax_n;
    logic [7:0]     scale_q, scale_n;
    logic           last_q, last_n;
    logic           eot_q, eot_n;
    logic           err_q, err_n;
    logic           done_q, done_n;

    // Comparisons widened by one bit so x+STEP cannot wrap past the limit.
    function automatic logic row_end_f(input logic [W_X-1:0] x, input logic [W_W-1:0] xm);
        return (W_CX'(x) + W_CX'(STEP_X)) > W_CX'(xm);
    endfunction

    function automatic logic col_end_f(input logic [W_Y-1:0] y, input logic [W_H-1:0] ym);
        return (W_CY'(y) + W_CY'(STEP_Y)) > W_CY'(ym);
    endfunction

    // Next-state, next-position and pulse logic.
    always_comb begin
        state_n = state;
        x_n     = x_q;
        y_n     = y_q;
        xmax_n  = xmax_q;
        ymax_n  = ymax_q;
        scale_n = scale_q;
        last_n  = last_q;
        err_n   = 1'b0;
        done_n  = 1'b0;
        eot_n   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    if ((W_CX'(cfg_width) < W_CX'(WIN_W)) || (W_CY'(cfg_height) < W_CY'(WIN_H))) begin
                        err_n = 1'b1;
                    end else begin
                        xmax_n  = cfg_width - W_W'(WIN_W);
                        ymax_n  = cfg_height - W_H'(WIN_H);
                        scale_n = cfg_scale;
                        last_n  = cfg_last;
                        x_n     = '0;
                        y_n     = '0;
                        state_n = SCAN;
                    end
                end
            end
            SCAN: begin
                if (window_pos_ready) begin
                    if (!row_end_f(x_q, xmax_q)) begin
                        x_n = x_q + W_X'(STEP_X);
                    end else if (!col_end_f(y_q, ymax_q)) begin
                        x_n = '0;
                        y_n = y_q + W_Y'(STEP_Y);
                    end else begin
                        state_n = IDLE;
                        done_n  = last_q;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        eot_n = (state_n == SCAN) && last_n && row_end_f(x_n, xmax_n) && col_end_f(y_n, ymax_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            scale_q <= '0;
            last_q  <= 1'b0;
            eot_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            xmax_q  <= xmax_n;
            ymax_q  <= ymax_n;
            scale_q <= scale_n;
            last_q  <= last_n;
            eot_q   <= eot_n;
            err_q   <= err_n;
            done_q  <= done_n;
        end
    end

    assign cfg_ready        = (state == IDLE);
    assign busy             = (state == SCAN);
    assign window_pos_valid = (state == SCAN);
    assign window_pos_x     = x_q;
    assign window_pos_y     = y_q;
    assign window_pos_scale = scale_q;
    assign window_pos_eot   = eot_q;
    assign cfg_err          = err_q;
    assign frame_done       = done_q;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Randomized bench for window_scan_ctrl: unit-stride and stride-2 instances
// compared against a raster-list model of the expected window positions.
module tb_window_scan_ctrl;

    localparam int unsigned W_X = $clog2(45);
    localparam int unsigned W_Y = $clog2(45);
    localparam int unsigned W_W = $clog2(46);
    localparam int unsigned W_H = $clog2(46);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    logic cfg_v = 1'b0;
    logic ready_drv = 1'b0;
    logic [W_W-1:0] cfg_width = '0;
    logic [W_H-1:0] cfg_height = '0;
    logic [7:0] cfg_scale = '0;
    logic cfg_last = 1'b0;

    logic a_cfg_valid, a_ready, a_cfg_ready, a_err, a_valid, a_eot, a_busy, a_done;
    logic [7:0] a_scale;
    logic [W_X-1:0] a_x;
    logic [W_Y-1:0] a_y;
    logic b_cfg_valid, b_ready, b_cfg_ready, b_err, b_valid, b_eot, b_busy, b_done;
    logic [7:0] b_scale;
    logic [W_X-1:0] b_x;
    logic [W_Y-1:0] b_y;

    logic m_cfg_ready, m_err, m_valid, m_eot, m_busy, m_done;
    logic [7:0] m_scale;
    logic [W_X-1:0] m_x;
    logic [W_Y-1:0] m_y;

    assign a_cfg_valid = cfg_v & ~sel;
    assign b_cfg_valid = cfg_v & sel;
    assign a_ready     = ready_drv & ~sel;
    assign b_ready     = ready_drv & sel;
    assign m_cfg_ready = sel ? b_cfg_ready : a_cfg_ready;
    assign m_err       = sel ? b_err : a_err;
    assign m_valid     = sel ? b_valid : a_valid;
    assign m_eot       = sel ? b_eot : a_eot;
    assign m_busy      = sel ? b_busy : a_busy;
    assign m_done      = sel ? b_done : a_done;
    assign m_scale     = sel ? b_scale : a_scale;
    assign m_x         = sel ? b_x : a_x;
    assign m_y         = sel ? b_y : a_y;

    window_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_scale(cfg_scale), .cfg_last(cfg_last), .cfg_err(a_err),
        .window_pos_valid(a_valid), .window_pos_ready(a_ready),
        .window_pos_eot(a_eot), .window_pos_scale(a_scale),
        .window_pos_x(a_x), .window_pos_y(a_y),
        .busy(a_busy), .frame_done(a_done)
    );

    window_scan_ctrl #(.STEP_X(2), .STEP_Y(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_scale(cfg_scale), .cfg_last(cfg_last), .cfg_err(b_err),
        .window_pos_valid(b_valid), .window_pos_ready(b_ready),
        .window_pos_eot(b_eot), .window_pos_scale(b_scale),
        .window_pos_x(b_x), .window_pos_y(b_y),
        .busy(b_busy), .frame_done(b_done)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; bit eot;} beat_t;
    beat_t exp_q[$];
    int total = 0;
    int passed = 0;

    // Every window whose top-left lands on the stride grid and fits inside the image.
    task automatic build_model(input int w, input int h, input int sx, input int sy, input bit last);
        beat_t b;
        exp_q.delete();
        for (int yy = 0; yy <= h - 24; yy += sy)
            for (int xx = 0; xx <= w - 24; xx += sx) begin
                b.x = xx; b.y = yy; b.eot = 1'b0;
                exp_q.push_back(b);
            end
        if (last && exp_q.size() > 0) exp_q[exp_q.size()-1].eot = 1'b1;
    endtask

    task automatic do_scan(input int w, input int h, input logic [7:0] sc, input bit last,
                           input bit bp, input bit use2, input int abort_at);
        beat_t e;
        int n = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [W_X-1:0] px;
        logic [W_Y-1:0] py;
        logic [7:0] ps;
        logic pe;
        sel = use2;
        build_model(w, h, use2 ? 2 : 1, use2 ? 2 : 1, last);
        total++;
        if (m_cfg_ready !== 1'b1) $display("FAIL cfg_ready_before_scan got=%b want=1", m_cfg_ready);
        else passed++;
        cfg_width = W_W'(w); cfg_height = W_H'(h); cfg_scale = sc; cfg_last = last;
        cfg_v = 1'b1;
        @(posedge clk); #1;
        cfg_v = 1'b0;
        while (exp_q.size() > 0) begin
            if (cyc > 5000) begin
                total++;
                $display("FAIL scan_timeout beats=%0d remaining=%0d", n, exp_q.size());
                break;
            end
            ready_drv = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            total++;
            if (m_valid !== 1'b1 || m_busy !== 1'b1 || m_cfg_ready !== 1'b0)
                $display("FAIL scan_status beat=%0d valid=%b busy=%b cfg_ready=%b want 1/1/0",
                         n, m_valid, m_busy, m_cfg_ready);
            else passed++;
            if (stalled) begin
                total++;
                if (m_x !== px || m_y !== py || m_scale !== ps || m_eot !== pe)
                    $display("FAIL stall_stable got=(%0d,%0d,s%0d,e%b) want=(%0d,%0d,s%0d,e%b)",
                             m_x, m_y, m_scale, m_eot, px, py, ps, pe);
                else passed++;
            end
            px = m_x; py = m_y; ps = m_scale; pe = m_eot;
            if (ready_drv) begin
                e = exp_q.pop_front();
                total++;
                if (int'(m_x) != e.x || int'(m_y) != e.y || m_scale !== sc || m_eot !== e.eot
                    || $isunknown({m_x, m_y}))
                    $display("FAIL beat_%0d got=(%0d,%0d,s%0d,e%b) want=(%0d,%0d,s%0d,e%b)",
                             n, m_x, m_y, m_scale, m_eot, e.x, e.y, sc, e.eot);
                else passed++;
                n++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (abort_at >= 0 && n == abort_at) return;
        end
        ready_drv = 1'b0;
        total++;
        if (m_valid !== 1'b0 || m_cfg_ready !== 1'b1 || m_busy !== 1'b0 || m_done !== last)
            $display("FAIL scan_end valid=%b cfg_ready=%b busy=%b frame_done=%b want 0/1/0/%b",
                     m_valid, m_cfg_ready, m_busy, m_done, last);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (m_done !== 1'b0) $display("FAIL frame_done_pulse got=%b want=0", m_done);
        else passed++;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        #23;
        total++;
        if (a_cfg_ready !== 1'b1 || a_err !== 1'b0 || a_valid !== 1'b0 || a_eot !== 1'b0 ||
            a_x !== '0 || a_y !== '0 || a_scale !== 8'd0 || a_busy !== 1'b0 || a_done !== 1'b0)
            $display("FAIL reset_values got rdy=%b err=%b v=%b eot=%b x=%0d y=%0d s=%0d busy=%b fd=%b",
                     a_cfg_ready, a_err, a_valid, a_eot, a_x, a_y, a_scale, a_busy, a_done);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_scan();
        do_scan(45, 45, 8'd0, 1'b1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_stride();
        do_scan(45, 45, 8'd3, 1'b1, 1'b0, 1'b1, -1);
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_scan(30, 24, 8'd5, 1'b0, 1'b0, 1'b0, -1);
        do_scan(24, 24, 8'd6, 1'b1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        do_scan(45, 45, 8'd9, 1'b1, 1'b1, 1'b0, -1);
    endtask

    task automatic test_cfg_err();
        int dims[2][2] = '{'{23, 45}, '{45, 23}};
        sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cfg_width = W_W'(dims[i][0]); cfg_height = W_H'(dims[i][1]);
            cfg_scale = 8'd7; cfg_last = 1'b1;
            cfg_v = 1'b1;
            @(posedge clk); #1;
            cfg_v = 1'b0;
            total++;
            if (a_err !== 1'b1 || a_cfg_ready !== 1'b1 || a_valid !== 1'b0 || a_busy !== 1'b0)
                $display("FAIL cfg_err_%0d err=%b rdy=%b v=%b busy=%b want 1/1/0/0",
                         i, a_err, a_cfg_ready, a_valid, a_busy);
            else passed++;
            @(posedge clk); #1;
            total++;
            if (a_err !== 1'b0 || a_valid !== 1'b0)
                $display("FAIL cfg_err_pulse_%0d err=%b v=%b want 0/0", i, a_err, a_valid);
            else passed++;
        end
        do_scan(26, 25, 8'd8, 1'b1, 1'b1, 1'b0, -1);
    endtask

    task automatic test_reset_mid_scan();
        bit saw_done = 1'b0;
        ready_drv = 1'b1;
        do_scan(45, 45, 8'd2, 1'b1, 1'b0, 1'b0, 100);
        rst_n = 1'b0;
        #1;
        total++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_eot !== 1'b0 || a_cfg_ready !== 1'b1 ||
            a_x !== '0 || a_y !== '0)
            $display("FAIL reset_mid v=%b busy=%b eot=%b rdy=%b x=%0d y=%0d want 0/0/0/1/0/0",
                     a_valid, a_busy, a_eot, a_cfg_ready, a_x, a_y);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst_n = 1'b1;
            if (a_done !== 1'b0 || a_valid !== 1'b0) saw_done = 1'b1;
        end
        total++;
        if (saw_done) $display("FAIL reset_no_done frame_done/valid seen after reset, want none");
        else passed++;
        do_scan(25, 26, 8'd4, 1'b1, 1'b0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_stride();
        test_back_to_back();
        test_backpressure();
        test_cfg_err();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Window-position sequencer for the cascade classifier. It accepts one per-scale configuration at a time: scaled image size, scale index and a last-scale flag. For that scale it generates the raster-ordered stream of window positions (x, y, scale, eot) consumed by the classifier datapath and the detection-position collector. It marks the final window of the final scale with eot, pulses frame_done, and then waits for the next scale.

## Interface
Parameters:
- IMG_WIDTH, 45, maximum scaled image width in pixels
- IMG_HEIGHT, 45, maximum scaled image height in pixels
- WIN_W, 24, detection window width
- WIN_H, 24, detection window height
- STEP_X, 1, horizontal window stride (>=1)
- STEP_Y, 1, vertical window stride (>=1)
- W_X / W_Y (localparam), $clog2(IMG_WIDTH) / $clog2(IMG_HEIGHT), position widths
- W_W / W_H (localparam), $clog2(IMG_WIDTH+1) / $clog2(IMG_HEIGHT+1), dimension widths

Ports:
- clk  input  1  clock; single clock domain
- rst_n  input  1  reset, asynchronous, active-low
- cfg_valid  input  1  scale configuration valid
- cfg_ready  output  1  block idle; configuration can be accepted
- cfg_width  input  W_W  scaled image width
- cfg_height  input  W_H  scaled image height
- cfg_scale  input  8  scale index, passed through to the output
- cfg_last  input  1  this is the last scale of the frame
- cfg_err  output  1  one-cycle pulse: configuration rejected
- window_pos_valid  output  1  position beat valid
- window_pos_ready  input  1  downstream accepts the beat
- window_pos_eot  output  1  last window of the last scale
- window_pos_scale  output  8  scale index
- window_pos_x  output  W_X  window top-left x
- window_pos_y  output  W_Y  window top-left y
- busy  output  1  scan in progress
- frame_done  output  1  one-cycle pulse after the eot beat is accepted

## Operation
- States: IDLE and SCAN. cfg_ready = (state==IDLE). busy = (state==SCAN).
- **Config accept.** A configuration is accepted when cfg_valid & cfg_ready.
  - If cfg_width < WIN_W or cfg_height < WIN_H: pulse cfg_err, stay in IDLE, emit no beats, change no registers.
  - Otherwise, register the following and go to SCAN:
    - x_max = cfg_width-WIN_W
    - y_max = cfg_height-WIN_H
    - scale = cfg_scale
    - last = cfg_last
    - x = 0, y = 0
- **SCAN.**
  - window_pos_valid = 1.
  - window_pos_x and window_pos_y come directly from the x/y registers; scale comes from its register.
  - window_pos_eot = last & row_end & col_end, where row_end = (x+STEP_X > x_max) and col_end = (y+STEP_Y > y_max). These comparisons are done at W_W/W_H+1 bits so they cannot wrap.
- **Advance on window_pos_valid & window_pos_ready.**
  - If !row_end: x += STEP_X.
  - Else if !col_end: x = 0, y += STEP_Y.
  - Else (final window): return to IDLE. If last, pulse frame_done in the next cycle.
- Windows whose position does not land exactly on x_max/y_max are skipped. Coverage stops at the last stride position <= the maximum.
- Non-last scales never assert eot. Scales after a last scale start a new frame, with no hidden state carried over.

## Timing
- Reset values:
  - cfg_ready = 1
  - cfg_err = 0
  - window_pos_valid = 0
  - window_pos_eot = 0
  - window_pos_x = 0, window_pos_y = 0, window_pos_scale = 0
  - busy = 0
  - frame_done = 0
  - State = IDLE.
- Latency: configuration accepted at edge N; the first beat (0,0) is valid after edge N, i.e. in cycle N+1.
- Throughput: one window per cycle while window_pos_ready = 1.
- Backpressure: while valid & !ready, all window_pos_* outputs hold stable. valid never drops before a handshake.
- One bubble between scales: the final handshake returns to IDLE, and the next configuration is accepted no earlier than the following cycle.
- cfg_err and frame_done are registered single-cycle pulses.
- rst_n asserted mid-scan: all outputs go to their reset values immediately. The beat in flight is abandoned. No eot and no frame_done are produced.
- cfg_valid during SCAN is ignored (cfg_ready = 0); the configuration must be held until it is accepted.

## Test plan
- Defaults, cfg 45x45 scale 0 last=1, ready always 1 -> 484 beats in raster order (0,0)..(21,21); eot only on (21,21); frame_done one cycle later; first beat the cycle after accept.
- STEP_X=STEP_Y=2, cfg 45x45 -> 121 beats, x,y in {0,2,..,20}; last beat (20,20).
- cfg 30x24 last=0 then 24x24 last=1 -> 7 beats with y=0, no eot, then 1 beat (0,0) with eot; one idle bubble between the scales.
- Random window_pos_ready backpressure on the 45x45 scan -> outputs stable while stalled; 484 unique beats; no drops or duplicates.
- cfg 23x45 -> cfg_err pulse, no beats, cfg_ready stays 1; a following valid cfg scans normally.
- rst_n low at beat 100 of a scan -> valid=0 and busy=0 immediately; no frame_done; a new cfg after reset starts again at (0,0).
